pc_fetch_sequencer: RTL and testbench

Owns the 8-bit program counter and runs instruction fetch for the core. Drives an instruction-memory request/acknowledge handshake and holds each fetched word in a one-entry buffer until decode accepts it. Applies branch redirects from decode as pc+1+offset. Sequences start, halt and fetch-timeout fault.

---
 rtl/pc_fetch_sequencer_if.sv | 44 ++++
 rtl/pc_fetch_sequencer.sv | 131 +++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// pc_fetch_sequencer_if
// Fetch/decode bus of the PC fetch sequencer: control levels, instruction
// memory request/acknowledge handshake, one-entry instruction buffer toward
// decode, branch redirect and status.
// Revision: 1.0 - initial release
// ============================================================================
interface pc_fetch_sequencer_if #(
    parameter int DATA_W = 16
);
    logic              run;
    logic              halt_req;
    logic              imem_req;
    logic [7:0]        imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_data;
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic [7:0]        instr_pc;
    logic              instr_ready;
    logic              branch_taken;
    logic [7:0]        branch_offset;
    logic [7:0]        pc;
    logic              halted;
    logic              fault;

    // Sequencer side
    modport master (
        input  run, halt_req, imem_ack, imem_data, instr_ready,
               branch_taken, branch_offset,
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
               pc, halted, fault
    );

    // Environment side (memory, decode, control)
    modport slave (
        output run, halt_req, imem_ack, imem_data, instr_ready,
               branch_taken, branch_offset,
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
               pc, halted, fault
    );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// pc_fetch_sequencer
// Owns the 8-bit program counter, runs the instruction-memory handshake,
// buffers one fetched word for decode, applies branch redirects
// (pc = instr_pc + 1 + offset) and sequences start/halt/fetch-timeout fault.
// Revision: 1.0 - initial release
// ============================================================================
module pc_fetch_sequencer #(
    parameter int         DATA_W   = 16,
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter int         TIMEOUT  = 15
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    pc_fetch_sequencer_if.master bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_DELIVER = 3'd2;
    localparam logic [2:0] S_HALT    = 3'd3;
    localparam logic [2:0] S_FAULT   = 3'd4;

    // tmo_q counts FETCH cycles already spent without ack; the cycle in
    // which it reaches TIMEOUT-1 is the TIMEOUT-th unacknowledged cycle.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [2:0]        state_q,    state_d;
    logic [7:0]        pc_q,       pc_d;
    logic [DATA_W-1:0] instr_q,    instr_d;
    logic [7:0]        instr_pc_q, instr_pc_d;
    logic [7:0]        tmo_q,      tmo_d;
    logic              fault_q,    fault_d;

    logic              w_accept;
    logic [7:0]        w_branch_pc;

    assign w_accept    = (state_q == S_DELIVER) && bus.instr_ready;
    // 8-bit modular add is identical to adding the sign-extended offset
    assign w_branch_pc = instr_pc_q + 8'd1 + bus.branch_offset;

    // Next-state and datapath decisions
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        tmo_d      = tmo_q;
        fault_d    = fault_q;
        case (state_q)
            S_IDLE: begin
                if (bus.halt_req) begin
                    state_d = S_HALT;
                end else if (bus.run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (bus.imem_ack) begin
                    instr_d    = bus.imem_data;
                    instr_pc_d = pc_q;
                    pc_d       = pc_q + 8'd1;
                    tmo_d      = 8'd0;
                    state_d    = S_DELIVER;
                end else if (tmo_q == TMO_LAST) begin
                    fault_d = 1'b1;
                    state_d = S_FAULT;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_DELIVER: begin
                if (w_accept) begin
                    if (bus.branch_taken) begin
                        pc_d = w_branch_pc;
                    end
                    if (bus.halt_req) begin
                        state_d = S_HALT;
                    end else if (!bus.run) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                if (bus.run && !bus.halt_req) begin
                    state_d = S_FETCH;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= 8'd0;
            tmo_q      <= 8'd0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            tmo_q      <= tmo_d;
            fault_q    <= fault_d;
        end
    end

    // Outputs decode directly from state so reset drops the request at once
    assign bus.imem_req    = (state_q == S_FETCH);
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = (state_q == S_DELIVER);
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.pc          = pc_q;
    assign bus.halted      = (state_q == S_HALT);
    assign bus.fault       = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// tb_pc_fetch_sequencer
// Self-checking bench: memory responder process plus a PC reference model
// (next-address arithmetic) driving per-feature scenario tasks.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pc_fetch_sequencer;

    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pc_fetch_sequencer_if #(.DATA_W(DATA_W)) bus ();

    pc_fetch_sequencer #(
        .DATA_W  (DATA_W),
        .RESET_PC(8'h00),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    // memory responder controls
    bit mem_en    = 1'b1;
    bit mem_spur  = 1'b0;
    int mem_delay = 1;
    int mem_wait  = 0;

    // model: address of the pending / next instruction to be delivered
    logic [7:0] m_pc;

    function automatic logic [15:0] mem_word(input logic [7:0] a);
        return 16'hA000 + {8'h00, a};
    endfunction

    function automatic logic [7:0] branch_target(input logic [7:0] ipc, input logic [7:0] off);
        int t;
        t = int'(ipc) + 1 + int'($signed(off));
        t = ((t % 256) + 256) % 256;
        return 8'(t);
    endfunction

    // Memory: acks after mem_delay waiting cycles, optional stray acks when idle
    initial begin
        bus.imem_ack  = 1'b0;
        bus.imem_data = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_en && bus.imem_req) begin
                if (mem_wait >= mem_delay) begin
                    bus.imem_ack  = 1'b1;
                    bus.imem_data = mem_word(bus.imem_addr);
                    mem_wait      = 0;
                end else begin
                    bus.imem_ack = 1'b0;
                    mem_wait++;
                end
            end else begin
                mem_wait      = 0;
                bus.imem_ack  = mem_spur ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.imem_data = DATA_W'($urandom);
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        bus.run           = 1'b0;
        bus.halt_req      = 1'b0;
        bus.instr_ready   = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_offset = 8'h00;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        m_pc  = 8'h00;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (bus.instr_valid) begin
                ok = 1'b1;
                return;
            end
            step();
        end
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (bus.imem_req) begin
                ok = 1'b1;
                return;
            end
            step();
        end
    endtask

    // one accept cycle; the model moves to the next delivery address
    task automatic accept(input bit br, input logic [7:0] off);
        bus.instr_ready   = 1'b1;
        bus.branch_taken  = br;
        bus.branch_offset = off;
        step();
        bus.instr_ready   = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_offset = 8'h00;
        m_pc = br ? branch_target(m_pc, off) : m_pc + 8'd1;
    endtask

    task automatic go_to(input logic [7:0] target, output bit ok);
        wait_valid(ok);
        if (!ok) return;
        accept(1'b1, target - m_pc - 8'd1);
    endtask

    task automatic test_reset();
        bus.run = 1'b0;
        rst_n = 1'b0;
        #1;
        total++; if (bus.pc !== 8'h00) begin bad++; $display("FAIL reset_pc: got %h want 00", bus.pc); end
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
        total++; if (bus.instr_valid !== 1'b0 || bus.instr !== 16'h0 || bus.instr_pc !== 8'h00) begin
            bad++; $display("FAIL reset_buf: valid=%b instr=%h ipc=%h want 0/0000/00", bus.instr_valid, bus.instr, bus.instr_pc); end
        total++; if (bus.halted !== 1'b0 || bus.fault !== 1'b0) begin
            bad++; $display("FAIL reset_status: halted=%b fault=%b want 0/0", bus.halted, bus.fault); end
        do_reset();
        step();
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL idle_quiet: req=%b want 0", bus.imem_req); end
    endtask

    task automatic test_sequential();
        bit ok;
        do_reset();
        mem_en = 1'b1; mem_spur = 1'b0; mem_delay = 1;
        bus.run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_valid(ok);
            total++; if (!ok) begin bad++; $display("FAIL seq_timeout: valid never seen at step %0d", i); return; end
            total++; if (bus.instr !== mem_word(m_pc)) begin bad++; $display("FAIL seq_instr: got %h want %h", bus.instr, mem_word(m_pc)); end
            total++; if (bus.instr_pc !== m_pc) begin bad++; $display("FAIL seq_ipc: got %h want %h", bus.instr_pc, m_pc); end
            accept(1'b0, 8'h00);
        end
        total++; if (bus.pc !== 8'h03) begin bad++; $display("FAIL seq_pc3: got %h want 03", bus.pc); end
    endtask

    task automatic test_branch();
        bit ok;
        go_to(8'h10, ok);
        wait_valid(ok);
        total++; if (!ok || bus.instr_pc !== 8'h10) begin bad++; $display("FAIL br_at10: ok=%b ipc=%h want 10", ok, bus.instr_pc); end
        accept(1'b1, 8'h05);
        wait_req(ok);
        total++; if (!ok || bus.imem_addr !== 8'h16) begin bad++; $display("FAIL br_fwd: addr=%h want 16", bus.imem_addr); end
        go_to(8'h10, ok);
        wait_valid(ok);
        total++; if (!ok || bus.instr_pc !== 8'h10) begin bad++; $display("FAIL br_at10b: ok=%b ipc=%h want 10", ok, bus.instr_pc); end
        accept(1'b1, 8'hFC);
        wait_req(ok);
        total++; if (!ok || bus.imem_addr !== 8'h0D) begin bad++; $display("FAIL br_back: addr=%h want 0d", bus.imem_addr); end
    endtask

    task automatic test_wrap();
        bit ok;
        go_to(8'hFF, ok);
        wait_valid(ok);
        total++; if (!ok || bus.instr_pc !== 8'hFF || bus.instr !== mem_word(8'hFF)) begin
            bad++; $display("FAIL wrap_ff: ipc=%h instr=%h want ff/%h", bus.instr_pc, bus.instr, mem_word(8'hFF)); end
        total++; if (bus.pc !== 8'h00) begin bad++; $display("FAIL wrap_pc_inc: got %h want 00", bus.pc); end
        accept(1'b0, 8'h00);
        total++; if (bus.pc !== 8'h00) begin bad++; $display("FAIL wrap_pc_acc: got %h want 00", bus.pc); end
        go_to(8'hFE, ok);
        wait_valid(ok);
        accept(1'b1, 8'h02);
        total++; if (bus.pc !== 8'h01) begin bad++; $display("FAIL wrap_branch: got %h want 01", bus.pc); end
        wait_req(ok);
        total++; if (!ok || bus.imem_addr !== 8'h01) begin bad++; $display("FAIL wrap_addr: got %h want 01", bus.imem_addr); end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [15:0] e_instr;
        wait_valid(ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_timeout: valid never seen"); return; end
        e_instr = mem_word(m_pc);
        mem_spur = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.branch_taken  = ~bus.branch_taken;
            bus.branch_offset = 8'($urandom);
            step();
            total++; if (bus.instr !== e_instr || bus.instr_pc !== m_pc || bus.pc !== m_pc + 8'd1 ||
                         bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0) begin
                bad++; $display("FAIL bp_hold: instr=%h ipc=%h pc=%h v=%b req=%b want %h/%h/%h/1/0",
                                bus.instr, bus.instr_pc, bus.pc, bus.instr_valid, bus.imem_req, e_instr, m_pc, m_pc + 8'd1);
            end
        end
        mem_spur = 1'b0;
        accept(1'b0, 8'h00);
        total++; if (bus.pc !== m_pc) begin bad++; $display("FAIL bp_release: pc=%h want %h", bus.pc, m_pc); end
    endtask

    task automatic test_halt();
        bit ok;
        mem_delay = 3;
        wait_req(ok);
        bus.halt_req = 1'b1;
        wait_valid(ok);
        total++; if (!ok || bus.instr !== mem_word(m_pc)) begin bad++; $display("FAIL halt_deliver: ok=%b instr=%h want %h", ok, bus.instr, mem_word(m_pc)); end
        accept(1'b0, 8'h00);
        total++; if (bus.halted !== 1'b1 || bus.imem_req !== 1'b0) begin bad++; $display("FAIL halt_enter: halted=%b req=%b want 1/0", bus.halted, bus.imem_req); end
        step(); step();
        total++; if (bus.halted !== 1'b1 || bus.pc !== m_pc) begin bad++; $display("FAIL halt_hold: halted=%b pc=%h want 1/%h", bus.halted, bus.pc, m_pc); end
        bus.halt_req = 1'b0;
        step();
        total++; if (bus.halted !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== m_pc) begin
            bad++; $display("FAIL halt_resume: halted=%b req=%b addr=%h want 0/1/%h", bus.halted, bus.imem_req, bus.imem_addr, m_pc); end
        // idle path: run=0 at accept goes quiet, halt_req from idle halts
        wait_valid(ok);
        bus.run = 1'b0;
        accept(1'b0, 8'h00);
        step(); step();
        total++; if (bus.imem_req !== 1'b0 || bus.halted !== 1'b0 || bus.pc !== m_pc) begin
            bad++; $display("FAIL idle_stop: req=%b halted=%b pc=%h want 0/0/%h", bus.imem_req, bus.halted, bus.pc, m_pc); end
        bus.halt_req = 1'b1;
        step();
        total++; if (bus.halted !== 1'b1) begin bad++; $display("FAIL idle_halt: halted=%b want 1", bus.halted); end
        bus.halt_req = 1'b0;
        bus.run = 1'b1;
        mem_delay = 1;
        step();
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== m_pc) begin bad++; $display("FAIL idle_resume: req=%b addr=%h want 1/%h", bus.imem_req, bus.imem_addr, m_pc); end
    endtask

    task automatic test_timeout();
        bit ok;
        // never acknowledged: request held exactly TIMEOUT cycles
        do_reset();
        mem_en = 1'b0; mem_spur = 1'b0;
        bus.run = 1'b1;
        wait_req(ok);
        total++; if (!ok) begin bad++; $display("FAIL tmo_noreq: req never seen"); return; end
        for (int k = 1; k < TIMEOUT; k++) begin
            step();
            total++; if (bus.imem_req !== 1'b1 || bus.fault !== 1'b0) begin
                bad++; $display("FAIL tmo_wait: cycle %0d req=%b fault=%b want 1/0", k, bus.imem_req, bus.fault); end
        end
        step();
        total++; if (bus.fault !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
            bad++; $display("FAIL tmo_fault: fault=%b req=%b v=%b want 1/0/0", bus.fault, bus.imem_req, bus.instr_valid); end
        mem_spur = 1'b1;
        step(); step(); step();
        total++; if (bus.fault !== 1'b1 || bus.imem_req !== 1'b0 || bus.halted !== 1'b0) begin
            bad++; $display("FAIL tmo_sticky: fault=%b req=%b halted=%b want 1/0/0", bus.fault, bus.imem_req, bus.halted); end
        mem_spur = 1'b0;
        rst_n = 1'b0;
        #1;
        total++; if (bus.fault !== 1'b0 || bus.pc !== 8'h00 || bus.imem_req !== 1'b0) begin
            bad++; $display("FAIL tmo_reset: fault=%b pc=%h req=%b want 0/00/0", bus.fault, bus.pc, bus.imem_req); end
        // ack in the last allowed cycle wins
        do_reset();
        mem_en = 1'b1; mem_delay = TIMEOUT - 1;
        bus.run = 1'b1;
        wait_valid(ok);
        total++; if (!ok || bus.fault !== 1'b0 || bus.instr !== mem_word(8'h00)) begin
            bad++; $display("FAIL tmo_lastack: ok=%b fault=%b instr=%h want 1/0/%h", ok, bus.fault, bus.instr, mem_word(8'h00)); end
        // reset in the middle of a handshake drops the request immediately
        accept(1'b0, 8'h00);
        mem_en = 1'b0;
        wait_req(ok);
        rst_n = 1'b0;
        #1;
        total++; if (bus.imem_req !== 1'b0 || bus.pc !== 8'h00) begin bad++; $display("FAIL mid_reset: req=%b pc=%h want 0/00", bus.imem_req, bus.pc); end
        mem_en = 1'b1; mem_delay = 1;
        do_reset();
    endtask

    task automatic test_random();
        bit ok;
        bit br;
        logic [7:0] off;
        int bp;
        do_reset();
        mem_en = 1'b1; mem_spur = 1'b1;
        bus.run = 1'b1;
        for (int n = 0; n < 150; n++) begin
            mem_delay = $urandom_range(0, 4);
            ok = 1'b0;
            for (int c = 0; c < 40; c++) begin
                if (bus.instr_valid) begin ok = 1'b1; break; end
                if (bus.imem_req) begin
                    total++; if (bus.imem_addr !== m_pc) begin bad++; $display("FAIL rnd_addr: got %h want %h", bus.imem_addr, m_pc); end
                end
                step();
            end
            total++; if (!ok) begin bad++; $display("FAIL rnd_timeout: no delivery at item %0d", n); return; end
            total++; if (bus.instr !== mem_word(m_pc) || bus.instr_pc !== m_pc) begin
                bad++; $display("FAIL rnd_deliver: instr=%h ipc=%h want %h/%h", bus.instr, bus.instr_pc, mem_word(m_pc), m_pc); end
            bp = $urandom_range(0, 3);
            for (int b = 0; b < bp; b++) begin
                bus.branch_taken  = 1'($urandom);
                bus.branch_offset = 8'($urandom);
                step();
            end
            total++; if (bus.instr_valid !== 1'b1 || bus.instr !== mem_word(m_pc)) begin
                bad++; $display("FAIL rnd_hold: v=%b instr=%h want 1/%h", bus.instr_valid, bus.instr, mem_word(m_pc)); end
            br  = 1'($urandom);
            off = 8'($urandom);
            accept(br, off);
            total++; if (bus.pc !== m_pc) begin bad++; $display("FAIL rnd_pc: br=%b off=%h got %h want %h", br, off, bus.pc, m_pc); end
        end
        mem_spur = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.run = 1'b0; bus.halt_req = 1'b0; bus.instr_ready = 1'b0;
        bus.branch_taken = 1'b0; bus.branch_offset = 8'h00;
        m_pc = 8'h00;
        step();
        test_reset();
        test_sequential();
        test_branch();
        test_wrap();
        test_backpressure();
        test_halt();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
